peripheral_mpi_bus_arbiter: RTL

//  Shares the single generic bus port of one MPI buffer (message-passing NoC endpoint) between M bus masters (e.g. CPU, DMA).

---
 rtl/peripheral_mpi_bus_arbiter_if.sv | 31 +++
 rtl/peripheral_mpi_bus_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/peripheral_mpi_bus_arbiter_if.sv
// rtl/peripheral_mpi_bus_arbiter_if.sv - requester and MPI buffer bus signals of the arbiter
interface peripheral_mpi_bus_arbiter_if #(
    parameter int M = 2
);
    logic [M*32-1:0] req_addr;
    logic [M-1:0]    req_we;
    logic [M-1:0]    req_en;
    logic [M*32-1:0] req_data_in;
    logic [31:0]     req_data_out;
    logic [M-1:0]    req_ack;
    logic [M-1:0]    req_err;
    logic [M-1:0]    grant;
    logic [31:0]     bus_addr;
    logic            bus_we;
    logic            bus_en;
    logic [31:0]     bus_data_in;
    logic [31:0]     bus_data_out;
    logic            bus_ack;
    logic            bus_err;

    // master: the arbiter itself, which owns the buffer bus
    modport master (
        input  req_addr, req_we, req_en, req_data_in, bus_data_out, bus_ack, bus_err,
        output req_data_out, req_ack, req_err, grant, bus_addr, bus_we, bus_en, bus_data_in
    );

    modport slave (
        output req_addr, req_we, req_en, req_data_in, bus_data_out, bus_ack, bus_err,
        input  req_data_out, req_ack, req_err, grant, bus_addr, bus_we, bus_en, bus_data_in
    );
endinterface

// File: rtl/peripheral_mpi_bus_arbiter.sv
// rtl/peripheral_mpi_bus_arbiter.sv - round-robin share of one MPI buffer bus port with timeout watchdog
module peripheral_mpi_bus_arbiter #(
    parameter int M       = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    peripheral_mpi_bus_arbiter_if.master  io
);
    localparam int             PW       = (M > 1) ? $clog2(M) : 1;
    localparam int             CW       = $clog2(TIMEOUT + 2);
    localparam bit             WD_EN    = (TIMEOUT != 0);
    localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [PW-1:0]  LAST_REQ = PW'(M - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [CW-1:0]   cnt;

    logic [31:0]     req_data_out;
    logic [M-1:0]    req_ack;
    logic [M-1:0]    req_err;
    logic [M-1:0]    grant;
    logic [31:0]     bus_addr;
    logic            bus_we;
    logic            bus_en;
    logic [31:0]     bus_data_in;

    logic            pick_found;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   cand;

    // Scan from the farthest offset down so the requester closest to ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = M - 1; off >= 0; off--) begin
            cand = PW'((int'(ptr) + off) % M);
            if (io.req_en[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ptr          <= '0;
            owner        <= '0;
            cnt          <= '0;
            req_data_out <= '0;
            req_ack      <= '0;
            req_err      <= '0;
            grant        <= '0;
            bus_addr     <= '0;
            bus_we       <= 1'b0;
            bus_en       <= 1'b0;
            bus_data_in  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner       <= pick_idx;
                        grant       <= M'(1) << pick_idx;
                        bus_addr    <= io.req_addr[int'(pick_idx)*32 +: 32];
                        bus_data_in <= io.req_data_in[int'(pick_idx)*32 +: 32];
                        bus_we      <= io.req_we[pick_idx];
                        bus_en      <= 1'b1;
                        cnt         <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    // An error wins over a simultaneous ack; a write returns no data.
                    if (io.bus_err) begin
                        req_err      <= grant;
                        req_data_out <= '0;
                        bus_en       <= 1'b0;
                        state        <= DONE;
                    end else if (io.bus_ack) begin
                        req_ack      <= grant;
                        req_data_out <= bus_we ? 32'h0 : io.bus_data_out;
                        bus_en       <= 1'b0;
                        state        <= DONE;
                    end else if (WD_EN && cnt == CNT_LAST) begin
                        req_err      <= grant;
                        req_data_out <= '0;
                        bus_en       <= 1'b0;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    req_ack      <= '0;
                    req_err      <= '0;
                    req_data_out <= '0;
                    grant        <= '0;
                    ptr          <= (owner == LAST_REQ) ? '0 : owner + 1'b1;
                    cnt          <= '0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.req_data_out = req_data_out;
    assign io.req_ack      = req_ack;
    assign io.req_err      = req_err;
    assign io.grant        = grant;
    assign io.bus_addr     = bus_addr;
    assign io.bus_we       = bus_we;
    assign io.bus_en       = bus_en;
    assign io.bus_data_in  = bus_data_in;
endmodule
